// File: rtl/ipv4_pkg.sv
// Shared constants, FSM state type and header-word helper for the IPv4 transmit path.
package ipv4_pkg;

  localparam logic [7:0]  VER_IHL     = 8'h45;
  localparam logic [7:0]  TOS         = 8'h00;
  localparam logic [15:0] FLAGS_DF    = 16'h4000;
  localparam int unsigned HDR_WORDS   = 10;
  localparam logic [15:0] HDR_BYTES   = 16'd20;
  localparam logic [15:0] MAX_PAYLOAD = 16'd65515;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  // Big-endian 16-bit header word at position idx (0..9); word 5 is the checksum slot.
  function automatic logic [15:0] hdr_word(
    input logic [3:0]  idx,
    input logic [15:0] tot_len,
    input logic [15:0] id,
    input logic [7:0]  ttl,
    input logic [7:0]  prot,
    input logic [15:0] csum,
    input logic [31:0] src,
    input logic [31:0] dst
  );
    logic [15:0] w;
    case (idx)
      4'd0:    w = {VER_IHL, TOS};
      4'd1:    w = tot_len;
      4'd2:    w = id;
      4'd3:    w = FLAGS_DF;
      4'd4:    w = {ttl, prot};
      4'd5:    w = csum;
      4'd6:    w = src[31:16];
      4'd7:    w = src[15:0];
      4'd8:    w = dst[31:16];
      4'd9:    w = dst[15:0];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Ones-complement checksum of the nine non-checksum IPv4 header words.
module ipv4_csum
  import ipv4_pkg::*;
(
  input  logic [9*16-1:0] i_words,
  output logic [15:0]     o_csum
);

  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  // Wide sum, then two end-around-carry folds; the second fold cannot carry again.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      w_sum = w_sum + {4'd0, i_words[i*16 +: 16]};
    end
    w_fold1 = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
    w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};
    o_csum  = ~w_fold2;
  end

endmodule

// File: rtl/ipv4_tx.sv
// IPv4 header prepender: emits a 20-byte header, then passes the transport payload through.
module ipv4_tx
  import ipv4_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       KEEP_W   = DATA_W / 8,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       PROT_W   = 8,
  parameter logic [PROT_W-1:0] PROTOCOL = 8'd17,
  parameter logic [7:0]        TTL      = 8'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_v_i,
  output logic              start_rdy_o,
  input  logic [15:0]       start_len_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic              s_valid_i,
  output logic              s_rdy_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  input  logic              s_cancel_i,
  output logic              m_valid_o,
  input  logic              m_rdy_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o,
  output logic              m_cancel_o
);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [15:0]       r_id;
  logic [15:0]       r_cur_id;
  logic [15:0]       r_csum;
  logic [3:0]        r_hdr_idx;
  logic [15:0]       r_hdr_word;
  logic [16:0]       r_bytes;

  logic [15:0]       w_tot_len;
  logic [9*16-1:0]   w_words;
  logic [15:0]       w_csum;
  logic [16:0]       w_keep_bytes;
  logic [16:0]       w_beat_bytes;
  logic [16:0]       w_bytes_total;
  logic              w_len_mismatch;

  assign w_tot_len = r_len + HDR_BYTES;

  // Gather the nine header words that feed the checksum (slot 5 is skipped).
  always_comb begin
    w_words = '0;
    for (int unsigned j = 0; j < 9; j++) begin
      w_words[j*16 +: 16] = hdr_word(4'((j < 5) ? j : j + 1), w_tot_len, r_cur_id,
                                     TTL, PROTOCOL, 16'h0000, r_src, r_dst);
    end
  end

  ipv4_csum u_csum (
    .i_words (w_words),
    .o_csum  (w_csum)
  );

  // Bytes carried by the current payload beat; only the last beat may be partial.
  always_comb begin
    w_keep_bytes = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      w_keep_bytes = w_keep_bytes + 17'(s_keep_i[i]);
    end
    w_beat_bytes   = s_last_i ? w_keep_bytes : 17'(KEEP_W);
    w_bytes_total  = r_bytes + w_beat_bytes;
    w_len_mismatch = (w_bytes_total != {1'b0, r_len});
  end

  // Packet sequencing: request capture, checksum, header beats, payload, drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_id       <= '0;
      r_cur_id   <= '0;
      r_csum     <= '0;
      r_hdr_idx  <= '0;
      r_hdr_word <= '0;
      r_bytes    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_v_i) begin
            r_len     <= start_len_i;
            r_src     <= src_addr_i;
            r_dst     <= dst_addr_i;
            r_cur_id  <= r_id;
            r_id      <= r_id + 16'd1;
            r_bytes   <= '0;
            r_hdr_idx <= '0;
            r_state   <= (start_len_i > MAX_PAYLOAD) ? DROP : CSUM;
          end
        end
        CSUM: begin
          r_csum     <= w_csum;
          r_hdr_word <= hdr_word(4'd0, w_tot_len, r_cur_id, TTL, PROTOCOL, w_csum, r_src, r_dst);
          r_state    <= HDR;
        end
        HDR: begin
          if (m_rdy_i) begin
            if (r_hdr_idx == 4'(HDR_WORDS - 1)) begin
              r_state <= PAYLOAD;
            end else begin
              r_hdr_idx  <= r_hdr_idx + 4'd1;
              r_hdr_word <= hdr_word(r_hdr_idx + 4'd1, w_tot_len, r_cur_id, TTL, PROTOCOL,
                                     r_csum, r_src, r_dst);
            end
          end
        end
        PAYLOAD: begin
          if (s_valid_i && m_rdy_i) begin
            // Saturate once past 64 KiB: any such count already mismatches.
            r_bytes <= r_bytes[16] ? r_bytes : w_bytes_total;
            if (s_last_i || s_cancel_i) begin
              r_state <= IDLE;
            end
          end
        end
        DROP: begin
          if (s_valid_i && (s_last_i || s_cancel_i)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output steering: header from the registered word, payload straight through.
  always_comb begin
    start_rdy_o = 1'b0;
    s_rdy_o     = 1'b0;
    m_valid_o   = 1'b0;
    m_data_o    = '0;
    m_keep_o    = '0;
    m_last_o    = 1'b0;
    m_cancel_o  = 1'b0;
    case (r_state)
      IDLE: start_rdy_o = 1'b1;
      HDR: begin
        m_valid_o = 1'b1;
        m_data_o  = {r_hdr_word[7:0], r_hdr_word[15:8]};
        m_keep_o  = '1;
      end
      PAYLOAD: begin
        m_valid_o  = s_valid_i;
        s_rdy_o    = m_rdy_i;
        m_data_o   = s_data_i;
        m_keep_o   = s_last_i ? s_keep_i : '1;
        m_last_o   = s_valid_i && (s_last_i || s_cancel_i);
        m_cancel_o = s_valid_i && (s_cancel_i || (s_last_i && w_len_mismatch));
      end
      DROP: s_rdy_o = 1'b1;
      default: ;
    endcase
  end

endmodule
